// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and helpers for the handshaked dual-port RAM.
// Revision: 1.0
`default_nettype none

package dpram_pkg;

  // Helpers work on a fixed maximum width; callers size-cast in and out.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef struct packed {
    logic                  acc;
    logic                  we;
    logic [MAX_BE_W-1:0]   be;
    logic [MAX_DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic                  wr_a;
    logic                  wr_b;
    logic [MAX_DATA_W-1:0] word_a;
    logic [MAX_DATA_W-1:0] word_b;
    logic [MAX_DATA_W-1:0] q_a;
    logic [MAX_DATA_W-1:0] q_b;
  } res_t;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BE_W; i++)
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  // On a same-address collision only port A writes, carrying the merged word.
  function automatic res_t resolve(
    input logic [MAX_DATA_W-1:0] old_a,
    input logic [MAX_DATA_W-1:0] old_b,
    input req_t                  ra,
    input req_t                  rb,
    input logic                  same,
    input logic                  prio_a,
    input logic                  rd_new
  );
    res_t                  r;
    logic [MAX_DATA_W-1:0] w;
    r.word_a = merge_be(old_a, ra.data, ra.be);
    r.word_b = merge_be(old_b, rb.data, rb.be);
    r.wr_a   = ra.acc & ra.we;
    r.wr_b   = rb.acc & rb.we;
    r.q_a    = ra.we ? r.word_a : old_a;
    r.q_b    = rb.we ? r.word_b : old_b;
    if (same) begin
      if (ra.we && rb.we) begin
        if (prio_a) begin
          w = merge_be(old_a, ra.data, ra.be);
          w = merge_be(w, rb.data, rb.be & ~ra.be);
        end else begin
          w = merge_be(old_a, rb.data, rb.be);
          w = merge_be(w, ra.data, ra.be & ~rb.be);
        end
        r.word_a = w;
        r.wr_b   = 1'b0;
        r.q_a    = w;
        r.q_b    = w;
      end else if (ra.we) begin
        r.q_b = rd_new ? r.word_a : old_a;
      end else if (rb.we) begin
        r.q_a = rd_new ? r.word_b : old_b;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_port_ctrl.sv
// dpram_port_ctrl: request ready generation and 1-deep response register.
// Revision: 1.0
`default_nettype none

module dpram_port_ctrl
  import dpram_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_accept,
  input  logic              i_rsp_ready,
  input  logic [DATA_W-1:0] i_word,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_q
);

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_q;

  assign o_ready     = !r_rsp_valid || i_rsp_ready;
  assign o_accept    = i_valid && o_ready && !rst;
  assign o_rsp_valid = r_rsp_valid;
  assign o_q         = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_q         <= '0;
    end else if (o_accept) begin
      r_rsp_valid <= 1'b1;
      r_q         <= i_word;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpram_hs.sv
// dpram_hs: dual-port RAM with valid/ready requests, byte enables and collision policy.
// Revision: 1.0
`default_nettype none

module dpram_hs
  import dpram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int WR_PRIO_A = 1,
  parameter int RD_NEW    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_a,
  output logic                      ready_a,
  input  logic                      we_a,
  input  logic [nbytes(DATA_W)-1:0] be_a,
  input  logic [ADDR_W-1:0]         addr_a,
  input  logic [DATA_W-1:0]         data_a,
  output logic                      rsp_valid_a,
  input  logic                      rsp_ready_a,
  output logic [DATA_W-1:0]         q_a,
  input  logic                      valid_b,
  output logic                      ready_b,
  input  logic                      we_b,
  input  logic [nbytes(DATA_W)-1:0] be_b,
  input  logic [ADDR_W-1:0]         addr_b,
  input  logic [DATA_W-1:0]         data_b,
  output logic                      rsp_valid_b,
  input  logic                      rsp_ready_b,
  output logic [DATA_W-1:0]         q_b
);

  localparam int   c_DEPTH  = 2 ** ADDR_W;
  localparam logic c_PRIO_A = (WR_PRIO_A != 0);
  localparam logic c_RD_NEW = (RD_NEW != 0);

  if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
    $error("dpram_hs: DATA_W must be a multiple of 8 and at most MAX_DATA_W");
  end

  logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

  logic        w_acc_a, w_acc_b, w_same, w_unused;
  logic [DATA_W-1:0] w_q_a, w_q_b;
  req_t        w_req_a, w_req_b;
  res_t        w_res;

  assign w_same = w_acc_a && w_acc_b && (addr_a == addr_b);

  always_comb begin
    w_req_a      = '0;
    w_req_a.acc  = w_acc_a;
    w_req_a.we   = we_a;
    w_req_a.be   = MAX_BE_W'(be_a);
    w_req_a.data = MAX_DATA_W'(data_a);
    w_req_b      = '0;
    w_req_b.acc  = w_acc_b;
    w_req_b.we   = we_b;
    w_req_b.be   = MAX_BE_W'(be_b);
    w_req_b.data = MAX_DATA_W'(data_b);
    w_res = resolve(MAX_DATA_W'(r_mem[addr_a]), MAX_DATA_W'(r_mem[addr_b]),
                    w_req_a, w_req_b, w_same, c_PRIO_A, c_RD_NEW);
  end

  assign w_q_a    = DATA_W'(w_res.q_a);
  assign w_q_b    = DATA_W'(w_res.q_b);
  assign w_unused = ^w_res;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_res.wr_a) r_mem[addr_a] <= DATA_W'(w_res.word_a);
    if (w_res.wr_b) r_mem[addr_b] <= DATA_W'(w_res.word_b);
  end

  dpram_port_ctrl #(.DATA_W(DATA_W)) u_port_a (
    .clk         (clk),
    .rst         (rst_n),
    .i_valid     (valid_a),
    .o_ready     (ready_a),
    .o_accept    (w_acc_a),
    .i_rsp_ready (rsp_ready_a),
    .i_word      (w_q_a),
    .o_rsp_valid (rsp_valid_a),
    .o_q         (q_a)
  );

  dpram_port_ctrl #(.DATA_W(DATA_W)) u_port_b (
    .clk         (clk),
    .rst         (rst_n),
    .i_valid     (valid_b),
    .o_ready     (ready_b),
    .o_accept    (w_acc_b),
    .i_rsp_ready (rsp_ready_b),
    .i_word      (w_q_b),
    .o_rsp_valid (rsp_valid_b),
    .o_q         (q_b)
  );

endmodule

`default_nettype wire

// File: doc/dpram_hs.md
Name: dpram_hs

Overview:
- Parametrised successor to the team's 8x64 dual-port RAM.
- Generic data and address width, plus per-byte write enables.
- Adds a backpressured response channel on each port and a defined same-address collision policy.
- Sits between two independent valid/ready masters (e.g. CPU-side and DMA-side) and shared on-chip storage; each port is a request channel plus a 1-deep response register.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8 (elaboration error otherwise)
ADDR_W, 6, address width; depth = 2**ADDR_W words
WR_PRIO_A, 1, simultaneous same-address writes: 1 = port A wins, 0 = port B wins
RD_NEW, 0, read-during-write on the other port at the same address: 0 = old data, 1 = new (forwarded) data

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-high (asserted = 1)
valid_a / valid_b  input  1  request valid
ready_a / ready_b  output  1  request ready
we_a / we_b  input  1  1 = write, 0 = read
be_a / be_b  input  DATA_W/8  byte-lane write enables; ignored on reads
addr_a / addr_b  input  ADDR_W  word address
data_a / data_b  input  DATA_W  write data
rsp_valid_a / rsp_valid_b  output  1  response valid
rsp_ready_a / rsp_ready_b  input  1  response accepted by master
q_a / q_b  output  DATA_W  response data

Behaviour:
- Reset (rst_n = 1 at a clk edge):
  - rsp_valid_x = 0 and q_x = 0; ready_x = 1 in the cycle after reset.
  - Memory contents are not cleared.
  - An accepted request whose response is pending is discarded.
  - A request presented during reset is not executed, even if ready_x was high.
- Request handshake:
  - Request accepted at an edge where valid_x & ready_x & !rst_n.
  - ready_x = !rsp_valid_x | rsp_ready_x, combinational, with no dependence on valid_x.
  - Master must hold request fields stable while valid_x & !ready_x.
- Latency:
  - rsp_valid_x rises the edge after acceptance: 1-cycle latency, and a throughput of 1 per cycle while rsp_ready_x = 1.
  - Response fire = rsp_valid_x & rsp_ready_x.
  - Same-cycle fire plus new acceptance loads the new response.
  - Fire with no new acceptance clears rsp_valid_x.
- Response hold: q_x is stable while rsp_valid_x & !rsp_ready_x. The port stalls (ready_x = 0) and the memory is untouched.
- Read response: q_x = mem[addr] as sampled at acceptance, subject to the collision rules below.
- Write:
  - mem[addr] byte i updated iff be_x[i] at the acceptance edge.
  - Response q_x = the resulting full word (merged old/new bytes): write-through echo.
  - A write with be_x = 0 leaves memory unchanged and still produces a response.
- Collisions (both ports accept the same addr at the same edge):
  - W/W: the winner per WR_PRIO_A writes its enabled bytes first; the loser's enabled bytes are then applied only on lanes the winner did not enable. Each port's echo returns the final stored word.
  - R/W: the reader gets the old word if RD_NEW = 0, or the post-write merged word if RD_NEW = 1. The writer echo is unaffected.
  - R/R: both return the same word.
- Different addresses: fully independent; no cross-port stall under any condition.
- Backpressure on one port never affects the other port's ready or response timing.

Decomposition:
- dpram_pkg holds:
  - byte-merge function merge_be(old, new, be)
  - collision-resolution function returning the final word and per-port read data, given both requests
  - localparam helper for DATA_W/8
- Sub-module dpram_port_ctrl, instantiated twice, owns:
  - ready generation
  - the response register (rsp_valid, q), fed the resolved word from the top
- Top holds the storage array and the collision logic.

Test Plan:
- Reset then A write addr 5, data 0xA5, be all-ones, rsp_ready_a = 1 -> rsp_valid_a the next cycle, q_a = 0xA5; B read addr 5 afterwards -> q_b = 0xA5 one cycle after acceptance.
- A holds rsp_ready_a = 0 after a read of addr 3 (value 0x3C) while valid_a stays high -> ready_a = 0, q_a stays 0x3C for 4 cycles; port B streams reads at 1 per cycle unaffected; releasing rsp_ready_a gives a fire and acceptance on the same edge.
- DATA_W = 32: write addr 0 = 0x11223344, then write 0xAABBCCDD with be = 4'b0101 -> echo and later read = 0x11BB33DD.
- Same edge, addr 7: A writes 0x11 and B writes 0x22 (full be) -> WR_PRIO_A = 1 stores 0x11 and both echoes = 0x11; WR_PRIO_A = 0 stores 0x22. Same edge, A writes 0x55 while B reads addr 7 (old 0x11) -> q_b = 0x11 with RD_NEW = 0, 0x55 with RD_NEW = 1.
- rst_n pulsed for 1 cycle while rsp_valid_b = 1 and rsp_ready_b = 0 -> rsp_valid_b = 0 and q_b = 0 after the edge; a subsequent read of previously written addr 9 (0x99) returns 0x99, confirming memory is retained.
